dsram_ctrl: RTL and testbench
=============================

Name: dsram_ctrl

Overview:
- Sequencer and arbiter in front of the single-port 256-bit data SRAM (dsram) of the L1.
- Shares the one SRAM port between two requesters: the line-fill engine (full-line writes) and the core load/store port (32-bit word accesses).
- The SRAM has no byte enables, so core stores are done as atomic read-modify-write (RMW).
- Sits between the L1 pipeline / fill logic and the dsram instance.

Parameters:
ADDR_WIDTH, 13, SRAM line-index width (matches dsram ADDR_WIDTH)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
core_valid  in  1  core request present
core_ready  out  1  core request accepted this cycle when core_valid&&core_ready
core_wr  in  1  1=store, 0=load
core_addr  in  ADDR_WIDTH+3  [ADDR_WIDTH+2:3]=line index, [2:0]=word select
core_be  in  4  store byte enables; be[i] covers word byte i
core_wdata  in  32  store data
core_rvalid  out  1  load data valid
core_rdata  out  32  load word
fill_valid  in  1  fill request present
fill_ready  out  1  fill accepted when fill_valid&&fill_ready
fill_addr  in  ADDR_WIDTH  fill line index
fill_data  in  256  fill line
ram_a  out  ADDR_WIDTH  SRAM address
ram_wd  out  256  SRAM write data
ram_write  out  1  SRAM write strobe
ram_read  out  1  SRAM read strobe
ram_rd  in  256  SRAM read data; valid the cycle after ram_read

Behaviour:
- Word w occupies line bits [32w+31:32w]; byte i of word w occupies bits [32w+8i+7:32w+8i].
- States:
  - IDLE: accepts one request per cycle.
  - MERGE: second cycle of an RMW.
- IDLE arbitration:
  - Only one requester valid: it is granted.
  - Both valid: round-robin. A 1-bit pointer selects the winner and flips to the loser after each contested grant.
  - Pointer reset value favours fill.
  - The ready of the loser is 0.
- In MERGE: core_ready=0 and fill_ready=0.
- Fill grant in cycle T: ram_a=fill_addr, ram_wd=fill_data, ram_write=1 in T. Stay in IDLE.
- Load grant in cycle T:
  - In T: ram_a=line, ram_read=1.
  - In T+1: core_rvalid=1, core_rdata=selected word of ram_rd, using the word select registered at T.
  - Loads are fully pipelined; a new grant is allowed in T+1.
- Store grant in cycle T:
  - In T: ram_read=1, ram_a=line. Register line, word select, be and wdata; go to MERGE.
  - In T+1 (MERGE): ram_a=registered line, ram_write=1, ram_wd=ram_rd with enabled bytes of the selected word replaced by wdata. Go to IDLE.
  - A store takes 2 SRAM cycles and is atomic; no request interleaves.
- Write forwarding:
  - Keep a register of the last written line index and its 256-bit data (fill or merged store).
  - A read (load or RMW read) issued in the cycle immediately after a write to the same line takes its data from the forward register, not ram_rd.
  - The controller does not rely on SRAM same-address read-after-write behaviour.
- Idle cycles: ram_read=0, ram_write=0. ram_a holds its last value (no toggling).
- ram_write and ram_read are never both 1.
- core_rvalid pulses for exactly one cycle per load; loads complete in order.
- Reset (async assert):
  - State=IDLE, pointer=fill, forward-valid=0.
  - core_rvalid=0, ram_write=0, ram_read=0, ram_a=0, ram_wd=0, core_rdata=0.
  - core_ready=0 and fill_ready=0 while rst_n=0.
  - A store in MERGE at reset is abandoned; no SRAM write occurs.
  - A load in flight produces no rvalid.
- Outputs are glitch-free with respect to the registered state. Ready signals are combinational from valid, state and pointer.

Test Plan:
- Fill line 5 with 0x0707…07 (byte pattern 0x07). Next cycle, load addr {5,3'd2} -> rvalid in the following cycle, rdata=0x07070707, data taken via the forward path.
- Store addr {5,3'd1}, be=4'b0101, wdata=0xAABBCCDD onto line 5 = 0x07 pattern. Expected: ram_read then ram_write in consecutive cycles; line word1=0x07BB07DD, all other words unchanged; ready=0 during MERGE.
- Fill and core valid together for 4 cycles from reset -> grants alternate fill, core, fill, core.
- 8 back-to-back loads of words 0–7 of a line preloaded with word w=w -> 8 consecutive rvalid cycles returning 0..7 in order, no bubbles.
- Store immediately followed by a load of the same word -> the load returns the merged value, via forwarding.
- Deassert rst_n during the MERGE cycle of a store -> ram_write stays 0, line contents unchanged, all outputs at reset values, a normal load succeeds after release.

Source files
------------

// File: rtl/dsram_ctrl_if.sv
// dsram_ctrl_if: core, fill and SRAM-side signals of the L1 data SRAM controller
interface dsram_ctrl_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                    core_valid;
  logic                    core_ready;
  logic                    core_wr;
  logic [ADDR_WIDTH+2:0]   core_addr;
  logic [3:0]              core_be;
  logic [31:0]             core_wdata;
  logic                    core_rvalid;
  logic [31:0]             core_rdata;
  logic                    fill_valid;
  logic                    fill_ready;
  logic [ADDR_WIDTH-1:0]   fill_addr;
  logic [255:0]            fill_data;
  logic [ADDR_WIDTH-1:0]   ram_a;
  logic [255:0]            ram_wd;
  logic                    ram_write;
  logic                    ram_read;
  logic [255:0]            ram_rd;
  modport slave (
    input  core_valid, core_wr, core_addr, core_be, core_wdata,
    input  fill_valid, fill_addr, fill_data, ram_rd,
    output core_ready, core_rvalid, core_rdata, fill_ready,
    output ram_a, ram_wd, ram_write, ram_read
  );
  modport master (
    output core_valid, core_wr, core_addr, core_be, core_wdata,
    output fill_valid, fill_addr, fill_data, ram_rd,
    input  core_ready, core_rvalid, core_rdata, fill_ready,
    input  ram_a, ram_wd, ram_write, ram_read
  );
endinterface

// File: rtl/dsram_ctrl.sv
// dsram_ctrl: round-robin arbiter and sequencer sharing the single-port L1 data SRAM
// between line fills and core word accesses; core stores run as two-cycle read-modify-write.
module dsram_ctrl #(
  parameter int ADDR_WIDTH = 13
) (
  input logic         clk,
  input logic         rst_n,
  dsram_ctrl_if.slave bus
);
  typedef enum logic {S_IDLE, S_MERGE} state_t;
  state_t                r_st;
  logic                  r_ptr;
  logic                  r_ld_pend;
  logic [2:0]            r_ld_ws;
  logic [ADDR_WIDTH-1:0] r_line;
  logic [2:0]            r_ws;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic                  r_wrote;
  logic [ADDR_WIDTH-1:0] r_fwd_a;
  logic [255:0]          r_fwd_d;
  logic                  r_hit;
  logic [ADDR_WIDTH-1:0] r_a_hold;
  logic [255:0]          r_wd_hold;
  logic                  w_idle;
  logic                  w_merge;
  logic                  w_gnt_fill;
  logic                  w_gnt_core;
  logic [ADDR_WIDTH-1:0] w_core_line;
  logic [2:0]            w_core_ws;
  logic [255:0]          w_src;
  logic [255:0]          w_merged;
  assign w_idle      = rst_n && r_st == S_IDLE;
  assign w_merge     = r_st == S_MERGE;
  assign w_core_line = bus.core_addr[ADDR_WIDTH+2:3];
  assign w_core_ws   = bus.core_addr[2:0];
  // r_ptr=1 gives the core priority on a contested cycle
  assign bus.fill_ready = w_idle && (!bus.core_valid || !r_ptr);
  assign bus.core_ready = w_idle && (!bus.fill_valid || r_ptr);
  assign w_gnt_fill     = bus.fill_valid && bus.fill_ready;
  assign w_gnt_core     = bus.core_valid && bus.core_ready;
  // a read issued right after a write to the same line never trusts the SRAM
  assign w_src = r_hit ? r_fwd_d : bus.ram_rd;
  always_comb begin
    w_merged = w_src;
    for (int b = 0; b < 4; b++)
      if (r_be[b]) w_merged[{r_ws, b[1:0], 3'b000} +: 8] = r_wdata[8*b +: 8];
  end
  assign bus.ram_read    = w_gnt_core;
  assign bus.ram_write   = w_gnt_fill || w_merge;
  assign bus.ram_a       = w_gnt_fill ? bus.fill_addr : w_gnt_core ? w_core_line :
                           w_merge ? r_line : r_a_hold;
  assign bus.ram_wd      = w_gnt_fill ? bus.fill_data : w_merge ? w_merged : r_wd_hold;
  assign bus.core_rvalid = r_ld_pend;
  assign bus.core_rdata  = r_ld_pend ? w_src[{r_ld_ws, 5'd0} +: 32] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= S_IDLE;
      r_ptr     <= 1'b0;
      r_ld_pend <= 1'b0;
      r_ld_ws   <= '0;
      r_line    <= '0;
      r_ws      <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_wrote   <= 1'b0;
      r_fwd_a   <= '0;
      r_fwd_d   <= '0;
      r_hit     <= 1'b0;
      r_a_hold  <= '0;
      r_wd_hold <= '0;
    end else begin
      r_ld_pend <= w_gnt_core && !bus.core_wr;
      r_hit     <= w_gnt_core && r_wrote && r_fwd_a == w_core_line;
      r_wrote   <= bus.ram_write;
      r_a_hold  <= bus.ram_a;
      r_wd_hold <= bus.ram_wd;
      if (w_gnt_core) r_ld_ws <= w_core_ws;
      if (bus.ram_write) begin
        r_fwd_a <= bus.ram_a;
        r_fwd_d <= bus.ram_wd;
      end
      if (bus.fill_valid && bus.core_valid && (w_gnt_fill || w_gnt_core)) r_ptr <= ~r_ptr;
      if (w_gnt_core && bus.core_wr) begin
        r_st    <= S_MERGE;
        r_line  <= w_core_line;
        r_ws    <= w_core_ws;
        r_be    <= bus.core_be;
        r_wdata <= bus.core_wdata;
      end else begin
        r_st    <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dsram_ctrl.sv
// tb_dsram_ctrl: random and directed traffic against a line-array reference model,
// with a lagging-write SRAM model so only forwarding can return freshly written data.
module tb_dsram_ctrl;
  localparam int AW = 13;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dsram_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
  dsram_ctrl #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [255:0] mem     [0:255];
  logic [255:0] ref_mem [0:255];
  logic [31:0]  exp_q [$];
  logic         p_v = 1'b0;
  logic [7:0]   p_a;
  logic [255:0] p_d;
  logic         st_pend = 1'b0;
  logic [7:0]   st_line;
  logic [255:0] st_val;
  logic         ld_next = 1'b0;
  logic [255:0] tmp;
  int           wi;
  logic [AW-1:0] la;
  logic [255:0] fd;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // SRAM whose writes land one cycle late: a read right after a write sees old data
  always @(posedge clk) begin
    bus.ram_rd <= bus.ram_read ? mem[bus.ram_a[7:0]] :
                  {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (p_v) mem[p_a] <= p_d;
    p_v <= bus.ram_write;
    p_a <= bus.ram_a[7:0];
    p_d <= bus.ram_wd;
  end

  // request observer: updates the reference lines and queues expected load words
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      st_pend = 1'b0;
      ld_next = 1'b0;
    end else begin
      if (ld_next) chk("rvalid_latency", bus.core_rvalid, 1);
      ld_next = 1'b0;
      if (st_pend) begin
        chk("merge_strobe", {bus.ram_write, bus.ram_read, bus.ram_a}, {1'b1, 1'b0, 5'd0, st_line});
        chk("merge_ready", {bus.core_ready, bus.fill_ready}, 0);
        ref_mem[st_line] = st_val;
        st_pend = 1'b0;
      end
      if (bus.fill_valid && bus.fill_ready) begin
        chk("fill_strobe", {bus.ram_write, bus.ram_read, bus.ram_a}, {1'b1, 1'b0, bus.fill_addr});
        chk("fill_wd", bus.ram_wd, bus.fill_data);
        ref_mem[bus.fill_addr[7:0]] = bus.fill_data;
      end
      if (bus.core_valid && bus.core_ready) begin
        chk("core_strobe", {bus.ram_read, bus.ram_write, bus.ram_a},
            {1'b1, 1'b0, bus.core_addr[AW+2:3]});
        tmp = ref_mem[bus.core_addr[10:3]];
        wi  = int'(bus.core_addr[2:0]);
        if (bus.core_wr) begin
          for (int b = 0; b < 4; b++)
            if (bus.core_be[b]) tmp[wi*32 + 8*b +: 8] = bus.core_wdata[8*b +: 8];
          st_val  = tmp;
          st_line = bus.core_addr[10:3];
          st_pend = 1'b1;
        end else begin
          exp_q.push_back(tmp[wi*32 +: 32]);
          ld_next = 1'b1;
        end
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.core_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected actual=%h required=no_response", bus.core_rdata);
        end else chk("load_data", bus.core_rdata, exp_q.pop_front());
      end
      if (bus.ram_read || bus.ram_write) chk("strobe_excl", bus.ram_read & bus.ram_write, 0);
    end
  end

  task automatic idle(input int n);
    bus.core_valid = 1'b0;
    bus.fill_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic core_req(input logic wr, input logic [AW-1:0] line, input logic [2:0] w,
                          input logic [3:0] be, input logic [31:0] wd);
    logic got;
    got = 1'b0;
    bus.core_valid = 1'b1;
    bus.core_wr    = wr;
    bus.core_addr  = {line, w};
    bus.core_be    = be;
    bus.core_wdata = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.core_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL core_req_timeout actual=no_ready required=ready");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_req(input logic [AW-1:0] line, input logic [255:0] d);
    logic got;
    got = 1'b0;
    bus.fill_valid = 1'b1;
    bus.fill_addr  = line;
    bus.fill_data  = d;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.fill_ready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fill_req_timeout actual=no_ready required=ready");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    bus.core_valid = 1'b0;
    bus.core_wr    = 1'b0;
    bus.core_addr  = '0;
    bus.core_be    = '0;
    bus.core_wdata = '0;
    bus.fill_valid = 1'b0;
    bus.fill_addr  = '0;
    bus.fill_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    // both requesters pending while reset is held
    bus.fill_valid = 1'b1;
    bus.fill_addr  = AW'(20);
    bus.fill_data  = 256'h1234_5678;
    bus.core_valid = 1'b1;
    bus.core_wr    = 1'b0;
    bus.core_addr  = {AW'(21), 3'd0};
    @(negedge clk);
    chk("rst_ctrl", {bus.core_ready, bus.fill_ready, bus.core_rvalid, bus.ram_read, bus.ram_write}, 0);
    chk("rst_ram_a", bus.ram_a, 0);
    chk("rst_ram_wd", bus.ram_wd, 0);
    chk("rst_rdata", bus.core_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arb_alternate", {bus.fill_ready, bus.core_ready}, (i % 2 == 1) ? 2'b01 : 2'b10);
      @(posedge clk);
      #1;
    end
    idle(3);
    // fill then immediate load: only forwarding yields the new data
    fill_req(AW'(5), {32{8'h07}});
    core_req(1'b0, AW'(5), 3'd2, 4'h0, 32'h0);
    bus.core_valid = 1'b0;
    @(negedge clk);
    chk("fwd_rvalid", bus.core_rvalid, 1);
    chk("fwd_rdata", bus.core_rdata, 32'h07070707);
    @(posedge clk);
    #1;
    core_req(1'b1, AW'(5), 3'd1, 4'b0101, 32'hAABBCCDD);
    idle(3);
    core_req(1'b0, AW'(5), 3'd1, 4'h0, 32'h0);
    bus.core_valid = 1'b0;
    @(negedge clk);
    chk("rmw_word1", bus.core_rdata, 32'h07BB07DD);
    @(posedge clk);
    #1;
    for (int w = 0; w < 8; w++) core_req(1'b0, AW'(5), 3'(w), 4'h0, 32'h0);
    idle(2);
    // store then load of the same word, back to back
    core_req(1'b1, AW'(9), 3'd3, 4'hF, 32'hCAFEF00D);
    core_req(1'b0, AW'(9), 3'd3, 4'h0, 32'h0);
    bus.core_valid = 1'b0;
    @(negedge clk);
    chk("st_fwd_rvalid", bus.core_rvalid, 1);
    chk("st_fwd_rdata", bus.core_rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    for (int w = 0; w < 8; w++) fd[32*w +: 32] = 32'(w);
    fill_req(AW'(10), fd);
    idle(3);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        bus.core_valid = 1'b1;
        bus.core_wr    = 1'b0;
        bus.core_addr  = {AW'(10), 3'(i)};
      end else bus.core_valid = 1'b0;
      @(negedge clk);
      if (i < 8) chk("b2b_ready", bus.core_ready, 1);
      if (i > 0) chk("b2b_rvalid", bus.core_rvalid, 1);
      @(posedge clk);
      #1;
    end
    idle(2);
    // reset arrives during the merge cycle of a store
    fill_req(AW'(11), {8{32'h5A5AA5A5}});
    idle(3);
    bus.core_valid = 1'b1;
    bus.core_wr    = 1'b1;
    bus.core_addr  = {AW'(11), 3'd0};
    bus.core_be    = 4'hF;
    bus.core_wdata = 32'h12345678;
    @(negedge clk);
    chk("abort_store_accept", bus.core_ready, 1);
    @(posedge clk);
    #1;
    bus.core_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {bus.ram_write, bus.ram_read, bus.core_ready, bus.fill_ready, bus.core_rvalid}, 0);
    chk("abort_ram_a", bus.ram_a, 0);
    chk("abort_ram_wd", bus.ram_wd, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    core_req(1'b0, AW'(11), 3'd0, 4'h0, 32'h0);
    bus.core_valid = 1'b0;
    @(negedge clk);
    chk("abort_load", bus.core_rdata, 32'h5A5AA5A5);
    @(posedge clk);
    #1;
    for (int c = 0; c < 600; c++) begin
      bus.fill_valid = ($urandom % 3) == 0;
      bus.fill_addr  = AW'($urandom_range(0, 7));
      bus.fill_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      la             = AW'($urandom_range(0, 7));
      bus.core_valid = $urandom % 2;
      bus.core_wr    = $urandom % 2;
      bus.core_addr  = {la, 3'($urandom % 8)};
      bus.core_be    = 4'($urandom);
      bus.core_wdata = $urandom;
      @(posedge clk);
      #1;
    end
    idle(1);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    chk("queue_drain", exp_q.size(), 0);
    idle(4);
    for (int i = 0; i < 32; i++) chk("mem_line", mem[i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
